// File: rtl/commit_trace_fifo.sv
// rtl/commit_trace_fifo.sv - commit trace capture FIFO with sequence numbering and drop accounting (optional TRACE_SRAM_EN)
module commit_trace_fifo #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     debug_commit,
  input  logic [63:0]              debug_pc,
  input  logic [4:0]               debug_rf_wnum,
  input  logic [63:0]              debug_rf_wdata,
  input  logic [7:0]               debug_sram_wen,
  input  logic [31:0]              debug_sram_waddr,
  input  logic [63:0]              debug_sram_wdata,
  output logic                     trace_valid,
  input  logic                     trace_ready,
  output logic [CNT_W-1:0]         trace_seq,
  output logic [63:0]              trace_pc,
  output logic [4:0]               trace_rf_wnum,
  output logic [63:0]              trace_rf_wdata,
`ifdef TRACE_SRAM_EN
  output logic [7:0]               trace_sram_wen,
  output logic [31:0]              trace_sram_waddr,
  output logic [63:0]              trace_sram_wdata,
`endif
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [CNT_W-1:0]         drop_cnt,
  input  logic                     clear
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CNT_W-1:0] seq_q;

  logic [CNT_W-1:0] mem_seq   [DEPTH];
  logic [63:0]      mem_pc    [DEPTH];
  logic [4:0]       mem_wnum  [DEPTH];
  logic [63:0]      mem_wdata [DEPTH];
`ifdef TRACE_SRAM_EN
  logic [7:0]       mem_swen   [DEPTH];
  logic [31:0]      mem_swaddr [DEPTH];
  logic [63:0]      mem_swdata [DEPTH];
`else
  logic unused_sram;
  assign unused_sram = ^{debug_sram_wen, debug_sram_waddr, debug_sram_wdata};
`endif

  logic deq;
  logic space;
  logic enq;
  logic drop;

  // A full FIFO still has room when the head leaves on the same edge, since the core cannot stall.
  assign trace_valid = (count != '0);
  assign deq         = trace_valid && trace_ready;
  assign space       = (count != FULL) || deq;
  assign enq         = debug_commit && space;
  assign drop        = debug_commit && !space;

  // Entry storage; contents need no reset because outputs are masked while empty.
  always_ff @(posedge clock) begin
    if (enq) begin
      mem_seq[wr_ptr]   <= seq_q;
      mem_pc[wr_ptr]    <= debug_pc;
      mem_wnum[wr_ptr]  <= debug_rf_wnum;
      mem_wdata[wr_ptr] <= (debug_rf_wnum == 5'd0) ? 64'd0 : debug_rf_wdata;
`ifdef TRACE_SRAM_EN
      mem_swen[wr_ptr]   <= debug_sram_wen;
      mem_swaddr[wr_ptr] <= (debug_sram_wen == 8'd0) ? 32'd0 : debug_sram_waddr;
      mem_swdata[wr_ptr] <= (debug_sram_wen == 8'd0) ? 64'd0 : debug_sram_wdata;
`endif
    end
  end

  // Pointers, occupancy and the sequence counter, which advances on stored and dropped commits alike.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      seq_q  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + AW'(1);
      if (deq) rd_ptr <= rd_ptr + AW'(1);
      case ({enq, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (debug_commit) seq_q <= seq_q + CNT_W'(1);
    end
  end

  // Loss accounting; a drop in the same cycle as clear wins so no loss is ever hidden.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (clear)
        drop_cnt <= CNT_W'(1);
      else if (drop_cnt != {CNT_W{1'b1}})
        drop_cnt <= drop_cnt + CNT_W'(1);
    end else if (clear) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end
  end

  // Head entry presented combinationally, zeroed while the FIFO is empty.
  always_comb begin
    trace_seq      = '0;
    trace_pc       = '0;
    trace_rf_wnum  = '0;
    trace_rf_wdata = '0;
`ifdef TRACE_SRAM_EN
    trace_sram_wen   = '0;
    trace_sram_waddr = '0;
    trace_sram_wdata = '0;
`endif
    if (trace_valid) begin
      trace_seq      = mem_seq[rd_ptr];
      trace_pc       = mem_pc[rd_ptr];
      trace_rf_wnum  = mem_wnum[rd_ptr];
      trace_rf_wdata = mem_wdata[rd_ptr];
`ifdef TRACE_SRAM_EN
      trace_sram_wen   = mem_swen[rd_ptr];
      trace_sram_waddr = mem_swaddr[rd_ptr];
      trace_sram_wdata = mem_swdata[rd_ptr];
`endif
    end
  end

endmodule

// File: tb/tb_commit_trace_fifo.sv
// tb/tb_commit_trace_fifo.sv - self-checking bench for commit_trace_fifo (optional TRACE_SRAM_EN)
module tb_commit_trace_fifo;

  localparam int DEPTH = 16;
  localparam int CNT_W = 16;

  typedef struct {
    logic [15:0] seq;
    logic [63:0] pc;
    logic [4:0]  wnum;
    logic [63:0] wdata;
    logic [7:0]  swen;
    logic [31:0] swaddr;
    logic [63:0] swdata;
  } ent_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic debug_commit = 1'b0;
  logic [63:0] debug_pc = '0;
  logic [4:0]  debug_rf_wnum = '0;
  logic [63:0] debug_rf_wdata = '0;
  logic [7:0]  debug_sram_wen = '0;
  logic [31:0] debug_sram_waddr = '0;
  logic [63:0] debug_sram_wdata = '0;
  logic trace_valid;
  logic trace_ready = 1'b0;
  logic [CNT_W-1:0] trace_seq;
  logic [63:0] trace_pc;
  logic [4:0]  trace_rf_wnum;
  logic [63:0] trace_rf_wdata;
  logic [7:0]  trace_sram_wen;
  logic [31:0] trace_sram_waddr;
  logic [63:0] trace_sram_wdata;
  logic [$clog2(DEPTH):0] count;
  logic overflow;
  logic [CNT_W-1:0] drop_cnt;
  logic clear = 1'b0;

  int checks = 0;
  int failures = 0;

  ent_t mq[$];
  ent_t log_q[$];
  logic [15:0] mseq;
  logic movf;
  logic [15:0] mdrop;

  always #5 clock = ~clock;

  commit_trace_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset),
    .debug_commit(debug_commit), .debug_pc(debug_pc),
    .debug_rf_wnum(debug_rf_wnum), .debug_rf_wdata(debug_rf_wdata),
    .debug_sram_wen(debug_sram_wen), .debug_sram_waddr(debug_sram_waddr),
    .debug_sram_wdata(debug_sram_wdata),
    .trace_valid(trace_valid), .trace_ready(trace_ready),
    .trace_seq(trace_seq), .trace_pc(trace_pc),
    .trace_rf_wnum(trace_rf_wnum), .trace_rf_wdata(trace_rf_wdata),
`ifdef TRACE_SRAM_EN
    .trace_sram_wen(trace_sram_wen), .trace_sram_waddr(trace_sram_waddr),
    .trace_sram_wdata(trace_sram_wdata),
`endif
    .count(count), .overflow(overflow), .drop_cnt(drop_cnt), .clear(clear)
  );

`ifndef TRACE_SRAM_EN
  assign trace_sram_wen   = '0;
  assign trace_sram_waddr = '0;
  assign trace_sram_wdata = '0;
`endif

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of entries plus loss bookkeeping.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      mq.delete();
      mseq = '0;
      movf = 1'b0;
      mdrop = '0;
    end else begin
      bit do_deq;
      bit room;
      ent_t e;
      do_deq = (mq.size() != 0) && trace_ready;
      room = (mq.size() < DEPTH) || do_deq;
      if (do_deq) void'(mq.pop_front());
      if (debug_commit && room) begin
        e.seq = mseq;
        e.pc = debug_pc;
        e.wnum = debug_rf_wnum;
        e.wdata = (debug_rf_wnum == 0) ? 64'd0 : debug_rf_wdata;
`ifdef TRACE_SRAM_EN
        e.swen = debug_sram_wen;
        e.swaddr = (debug_sram_wen == 0) ? 32'd0 : debug_sram_waddr;
        e.swdata = (debug_sram_wen == 0) ? 64'd0 : debug_sram_wdata;
`else
        e.swen = '0;
        e.swaddr = '0;
        e.swdata = '0;
`endif
        mq.push_back(e);
      end
      if (debug_commit && !room) begin
        movf = 1'b1;
        if (clear) mdrop = 16'd1;
        else if (mdrop != 16'hFFFF) mdrop = mdrop + 16'd1;
      end else if (clear) begin
        movf = 1'b0;
        mdrop = '0;
      end
      if (debug_commit) mseq = mseq + 16'd1;
    end
  end

  // Record every entry the consumer accepts.
  always @(posedge clock) begin
    if (!reset && trace_valid && trace_ready) begin
      ent_t a;
      a.seq = trace_seq; a.pc = trace_pc; a.wnum = trace_rf_wnum; a.wdata = trace_rf_wdata;
      a.swen = trace_sram_wen; a.swaddr = trace_sram_waddr; a.swdata = trace_sram_wdata;
      log_q.push_back(a);
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    if (!reset) begin
      ent_t h;
      h = '{default: '0};
      if (mq.size() != 0) h = mq[0];
      check("valid", trace_valid, mq.size() != 0);
      check("count", count, mq.size());
      check("overflow", overflow, movf);
      check("drop_cnt", drop_cnt, mdrop);
      check("seq", trace_seq, h.seq);
      check("pc", trace_pc, h.pc);
      check("wnum", trace_rf_wnum, h.wnum);
      check("wdata", trace_rf_wdata, h.wdata);
`ifdef TRACE_SRAM_EN
      check("swen", trace_sram_wen, h.swen);
      check("swaddr", trace_sram_waddr, h.swaddr);
      check("swdata", trace_sram_wdata, h.swdata);
`endif
    end
  end

  task automatic cyc(input logic c, input logic [63:0] pc, input logic [4:0] wn,
                     input logic [63:0] wd, input logic rdy, input logic clr);
    debug_commit = c; debug_pc = pc; debug_rf_wnum = wn; debug_rf_wdata = wd;
    trace_ready = rdy; clear = clr;
    @(negedge clock);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cyc(1'b0, 64'd0, 5'd0, 64'd0, rdy, 1'b0);
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++)
      cyc(1'b1, 64'h8000_0000 + 64'(4 * i), 5'(i + 1), 64'(i * 16 + 1), 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    // Reset state
    @(negedge clock);
    check("rst_valid", trace_valid, 0);
    check("rst_count", count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_drop", drop_cnt, 0);
    check("rst_pc", trace_pc, 0);
    reset = 1'b0;

    // Three back-to-back commits drained immediately
    log_q.delete();
    cyc(1'b1, 64'h8000_0000, 5'd1, 64'h11, 1'b1, 1'b0);
    check("t1_valid_after_first", trace_valid, 1);
    check("t1_head_seq", trace_seq, 0);
    check("t1_head_wdata", trace_rf_wdata, 64'h11);
    cyc(1'b1, 64'h8000_0004, 5'd0, 64'h22, 1'b1, 1'b0);
    cyc(1'b1, 64'h8000_0008, 5'd3, 64'h33, 1'b1, 1'b0);
    idle(3, 1'b1);
    check("t1_log_size", log_q.size(), 3);
    if (log_q.size() == 3) begin
      check("t1_seq0", log_q[0].seq, 0);
      check("t1_seq1", log_q[1].seq, 1);
      check("t1_seq2", log_q[2].seq, 2);
      check("t1_wdata0", log_q[0].wdata, 64'h11);
      check("t1_wdata1", log_q[1].wdata, 64'h0);
      check("t1_wdata2", log_q[2].wdata, 64'h33);
      check("t1_pc2", log_q[2].pc, 64'h8000_0008);
    end
    check("t1_count_end", count, 0);

    // Fill, overflow by one, drain, then continue numbering
    do_reset();
    fill(16);
    check("t2_count_full", count, 16);
    check("t2_no_ovf_yet", overflow, 0);
    cyc(1'b1, 64'h8000_0040, 5'd2, 64'h44, 1'b0, 1'b0);
    check("t2_count", count, 16);
    check("t2_overflow", overflow, 1);
    check("t2_drop_cnt", drop_cnt, 1);
    log_q.delete();
    idle(16, 1'b1);
    check("t2_log_size", log_q.size(), 16);
    for (int i = 0; i < log_q.size(); i++) check("t2_drain_seq", log_q[i].seq, i);
    cyc(1'b1, 64'h8000_0100, 5'd2, 64'h77, 1'b0, 1'b0);
    check("t2_next_seq", trace_seq, 17);
    check("t2_next_pc", trace_pc, 64'h8000_0100);

    // Full FIFO with simultaneous enqueue and dequeue
    do_reset();
    fill(16);
    log_q.delete();
    cyc(1'b1, 64'h8000_0200, 5'd7, 64'hAB, 1'b1, 1'b0);
    check("t3_count", count, 16);
    check("t3_overflow", overflow, 0);
    check("t3_drop", drop_cnt, 0);
    check("t3_head_seq", trace_seq, 1);
    idle(16, 1'b1);
    check("t3_log_size", log_q.size(), 17);
    if (log_q.size() == 17) begin
      check("t3_tail_seq", log_q[16].seq, 16);
      check("t3_tail_pc", log_q[16].pc, 64'h8000_0200);
      check("t3_tail_wdata", log_q[16].wdata, 64'hAB);
    end

    // Clear racing a drop
    do_reset();
    fill(16);
    for (int i = 0; i < 5; i++) cyc(1'b1, 64'h9000_0000, 5'd1, 64'h1, 1'b0, 1'b0);
    check("t4_drop5", drop_cnt, 5);
    cyc(1'b1, 64'h9000_0004, 5'd1, 64'h1, 1'b0, 1'b1);
    check("t4_ovf_drop_wins", overflow, 1);
    check("t4_cnt_drop_wins", drop_cnt, 1);
    cyc(1'b0, 64'h0, 5'd0, 64'h0, 1'b0, 1'b1);
    check("t4_ovf_cleared", overflow, 0);
    check("t4_cnt_cleared", drop_cnt, 0);
    check("t4_count_kept", count, 16);

    // Asynchronous reset mid-cycle with entries pending
    do_reset();
    fill(7);
    check("t5_count7", count, 7);
    #2 reset = 1'b1;
    #1;
    check("t5_async_valid", trace_valid, 0);
    check("t5_async_count", count, 0);
    check("t5_async_seq", trace_seq, 0);
    check("t5_async_pc", trace_pc, 0);
    @(negedge clock);
    reset = 1'b0;
    cyc(1'b1, 64'h8000_0300, 5'd4, 64'h99, 1'b0, 1'b0);
    check("t5_seq_restart", trace_seq, 0);
    check("t5_pc", trace_pc, 64'h8000_0300);

`ifdef TRACE_SRAM_EN
    // Store fields, including zeroing when no byte is written
    do_reset();
    debug_sram_wen = 8'h0F; debug_sram_waddr = 32'h1000; debug_sram_wdata = 64'hDEADBEEF;
    cyc(1'b1, 64'h8000_0400, 5'd0, 64'h5, 1'b0, 1'b0);
    debug_sram_wen = 8'h00; debug_sram_waddr = 32'h2000; debug_sram_wdata = 64'h55;
    cyc(1'b1, 64'h8000_0404, 5'd0, 64'h6, 1'b0, 1'b0);
    check("s_wen", trace_sram_wen, 8'h0F);
    check("s_waddr", trace_sram_waddr, 32'h1000);
    check("s_wdata", trace_sram_wdata, 64'hDEADBEEF);
    idle(1, 1'b1);
    check("s_wen0", trace_sram_wen, 0);
    check("s_waddr0", trace_sram_waddr, 0);
    check("s_wdata0", trace_sram_wdata, 0);
    idle(2, 1'b1);
`endif

    idle(2, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
